alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Host-side front end for the 8-bit ALU on the TinyTapeout pin budget.
//  Operands A, B and selector S share the single 8-bit ui_in bus, so they are
//  loaded serially: three load strobes capture A, then B, then S.
//  The block then launches the ALU, waits the ALU latency, registers the result
//  and holds it for uo_out with a valid flag.
//  It sits between the top-level pins and alu_8bits, on the pins' side.
// PARAMETERS
//  W        8  operand/result width
//  ALU_LAT  0  extra clk cycles the ALU result needs after its inputs settle (0..15)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous reset, active-high
//  ena        in   1  clock enable; 0 freezes every register (pin-level ena)
//  din        in   W  shared operand bus (ui_in)
//  ld         in   1  load strobe, level from a pin, rising-edge detected internally
//  abort      in   1  synchronous abort of the current transaction
//  alu_a      out  W  operand A to ALU (registered)
//  alu_b      out  W  operand B to ALU (registered)
//  alu_s      out  2  operation selector to ALU (registered)
//  alu_result in   W  result from ALU
//  result     out  W  captured result (drives uo_out)
//  res_valid  out  1  result holds a completed operation
//  busy       out  1  high while state == EXEC
//  op_count   out  8  number of completed operations, wraps 255->0
// BEHAVIOUR
//  Reset (rst=1 at an edge, regardless of ena):
//   - state=IDLE; alu_a, alu_b, result, op_count = 0; alu_s = 0
//   - res_valid = 0; busy = 0; ld_q = 0; lat counter = 0
//  ena=0: no register changes; an ld rise occurring then is not remembered.
//  ld_rise = ld & ~ld_q, with ld_q <= ld each enabled cycle.
//   - A long high level counts once.
//   - ld already high on the first enabled cycle after reset counts as a rise.
//  FSM (all transitions on an enabled edge):
//   IDLE   : ld_rise -> alu_a<=din, goto GET_B
//   GET_B  : ld_rise -> alu_b<=din, goto GET_OP
//   GET_OP : ld_rise -> alu_s<=din[1:0] (din[7:2] ignored), lat<=ALU_LAT, goto EXEC
//   EXEC   : ld ignored.
//            - lat!=0 -> lat<=lat-1
//            - lat==0 -> result<=alu_result, res_valid<=1, op_count<=op_count+1,
//              goto DONE
//   DONE   : hold result/res_valid. ld_rise -> alu_a<=din, res_valid<=0,
//            goto GET_B (back-to-back issue)
//  Latency:
//   - op captured at edge k -> result and res_valid update at edge k+1+ALU_LAT
//   - with ALU_LAT=0, res_valid rises on the edge after the S load
//  busy = (state==EXEC), combinational from the state register.
//  res_valid clears only on a new A load in DONE, abort, or rst.
//  abort=1 (enabled edge, any state):
//   - state<=IDLE, res_valid<=0
//   - result, op_count and alu_* keep their values
//   - abort has priority over ld_rise in the same cycle
//   - abort during EXEC discards the pending result; op_count is not incremented
//  rst has priority over abort and ena.
//  alu_* outputs change only on their own load; they are stable throughout EXEC.
// TESTING
//  1. Reset with ld=0; pulse ld three times with din = 0x12, 0x34, 0x00 (stub: 00=add)
//     -> res_valid=1 one cycle after the 3rd pulse; result=0x46; op_count=1.
//  2. ALU_LAT=3, stub adds 3 cycles of delay; load A=0xF0, B=0x0F, S=2'b11 (or)
//     -> busy high for exactly 4 cycles; result=0xFF appears at edge k+4.
//  3. Hold ld high for 10 cycles with din=0xAA, then pulse it twice
//     -> alu_a=0xAA captured once; the next two pulses load B and S, not A.
//  4. From DONE, pulse A=0x01 -> res_valid drops the same edge; finish B=0x01 S=00
//     -> result=0x02, op_count=2.
//  5. Assert abort together with ld in EXEC
//     -> state IDLE, res_valid=0, op_count unchanged, prior result retained.
//  6. ena=0 for 5 cycles mid-GET_B while toggling ld
//     -> no capture and no state change; run 256 operations -> op_count wraps to 0.

Source files
------------

// File: rtl/alu_seq_if.sv
// Bus between the pin-side host and the ALU operand sequencer.
// Carries the shared operand bus, the strobes, the ALU hookup and the status outputs.
interface alu_seq_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         ld;
  logic         abort;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_s;
  logic [W-1:0] alu_result;
  logic [W-1:0] result;
  logic         res_valid;
  logic         busy;
  logic [7:0]   op_count;

  modport master (
    output din, ld, abort, alu_result,
    input  alu_a, alu_b, alu_s, result, res_valid, busy, op_count
  );

  modport slave (
    input  din, ld, abort, alu_result,
    output alu_a, alu_b, alu_s, result, res_valid, busy, op_count
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Serial A/B/S loader for the 8-bit ALU: captures operands from a shared bus on
// ld rising edges, waits the ALU latency, then holds the result with a valid flag.
module alu_operand_sequencer #(
  parameter int W       = 8,
  parameter int ALU_LAT = 0
) (
  input logic     clk,
  input logic     rst,
  input logic     ena,
  alu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t         state_r, state_s;
  logic [W-1:0]   alu_a_r, alu_a_s;
  logic [W-1:0]   alu_b_r, alu_b_s;
  logic [1:0]     alu_s_r, alu_s_s;
  logic [W-1:0]   result_r, result_s;
  logic           res_valid_r, res_valid_s;
  logic [7:0]     op_count_r, op_count_s;
  logic [3:0]     lat_r, lat_s;
  logic           ld_q_r;
  logic           ld_rise_s;

  assign ld_rise_s = bus.ld & ~ld_q_r;

  // Next-state and datapath update; abort overrides any load in the same cycle.
  always_comb begin
    state_s     = state_r;
    alu_a_s     = alu_a_r;
    alu_b_s     = alu_b_r;
    alu_s_s     = alu_s_r;
    result_s    = result_r;
    res_valid_s = res_valid_r;
    op_count_s  = op_count_r;
    lat_s       = lat_r;
    if (bus.abort) begin
      state_s     = IDLE;
      res_valid_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ld_rise_s) begin
            alu_a_s = bus.din;
            state_s = GET_B;
          end else begin
            state_s = IDLE;
          end
        end
        GET_B: begin
          if (ld_rise_s) begin
            alu_b_s = bus.din;
            state_s = GET_OP;
          end else begin
            state_s = GET_B;
          end
        end
        GET_OP: begin
          if (ld_rise_s) begin
            alu_s_s = bus.din[1:0];
            lat_s   = LAT_INIT;
            state_s = EXEC;
          end else begin
            state_s = GET_OP;
          end
        end
        EXEC: begin
          if (lat_r != 4'd0) begin
            lat_s = lat_r - 4'd1;
          end else begin
            result_s    = bus.alu_result;
            res_valid_s = 1'b1;
            op_count_s  = op_count_r + 8'd1;
            state_s     = DONE;
          end
        end
        DONE: begin
          // A new A load starts the next operation and retires the shown result.
          if (ld_rise_s) begin
            alu_a_s     = bus.din;
            res_valid_s = 1'b0;
            state_s     = GET_B;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s     = IDLE;
          res_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; ena freezes everything, rst overrides ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_s_r     <= 2'b00;
      result_r    <= '0;
      res_valid_r <= 1'b0;
      op_count_r  <= 8'd0;
      lat_r       <= 4'd0;
      ld_q_r      <= 1'b0;
    end else if (ena) begin
      state_r     <= state_s;
      alu_a_r     <= alu_a_s;
      alu_b_r     <= alu_b_s;
      alu_s_r     <= alu_s_s;
      result_r    <= result_s;
      res_valid_r <= res_valid_s;
      op_count_r  <= op_count_s;
      lat_r       <= lat_s;
      ld_q_r      <= bus.ld;
    end
  end

  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_s     = alu_s_r;
  assign bus.result    = result_r;
  assign bus.res_valid = res_valid_r;
  assign bus.busy      = (state_r == EXEC);
  assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: a vector table on a zero-latency
// instance plus hand-written latency, wrap and reset sequences.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] din;
  logic       ld;
  logic       abort;

  int checks   = 0;
  int failures = 0;

  alu_seq_if #(.W(8)) b0 ();
  alu_seq_if #(.W(8)) b3 ();

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign b0.din        = din;
  assign b0.ld         = ld;
  assign b0.abort      = abort;
  assign b0.alu_result = alu_model(b0.alu_a, b0.alu_b, b0.alu_s);
  assign b3.din        = din;
  assign b3.ld         = ld;
  assign b3.abort      = abort;
  assign b3.alu_result = alu_model(b3.alu_a, b3.alu_b, b3.alu_s);

  alu_operand_sequencer #(.W(8), .ALU_LAT(0)) dut0 (.clk(clk), .rst(rst), .ena(ena), .bus(b0));
  alu_operand_sequencer #(.W(8), .ALU_LAT(3)) dut3 (.clk(clk), .rst(rst), .ena(ena), .bus(b3));

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       abort;
    logic       ld;
    logic [7:0] din;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] s;
    logic [7:0] res;
    logic       v;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic add(input logic e, input logic ab, input logic l, input logic [7:0] d,
                     input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                     input logic [7:0] res, input logic v, input logic bz,
                     input logic [7:0] cnt);
    vecs[nvec] = '{e, ab, l, d, a, b, s, res, v, bz, cnt};
    nvec++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    din = d;
    ld  = 1'b1;
    tick();
    ld  = 1'b0;
    tick();
  endtask

  function automatic logic [35:0] pack0();
    return {b0.alu_a, b0.alu_b, b0.alu_s, b0.result, b0.res_valid, b0.busy, b0.op_count};
  endfunction

  initial begin
    rst = 1'b1; ena = 1'b1; din = 8'h00; ld = 1'b0; abort = 1'b0;

    // Load A,B,S serially: A=12 B=34 S=add, then back-to-back A=01 B=01 S=add.
    add(1'b1, 1'b0, 1'b1, 8'h12, 8'h12, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 8'h12, 8'h12, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b1, 8'h34, 8'h12, 8'h34, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 8'h34, 8'h12, 8'h34, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b1, 8'h00, 8'h12, 8'h34, 2'd0, 8'h00, 1'b0, 1'b1, 8'd0);
    add(1'b1, 1'b0, 1'b0, 8'h00, 8'h12, 8'h34, 2'd0, 8'h46, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 8'h34, 2'd0, 8'h46, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'h34, 2'd0, 8'h46, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 2'd0, 8'h46, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 2'd0, 8'h46, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 2'd0, 8'h46, 1'b0, 1'b1, 8'd1);
    add(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 2'd0, 8'h02, 1'b1, 1'b0, 8'd2);
    // ld held high for 10 cycles counts once
    for (int i = 0; i < 10; i++)
      add(1'b1, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'h01, 2'd0, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'h01, 2'd0, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b1, 8'h55, 8'hAA, 8'h55, 2'd0, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'h55, 8'hAA, 8'h55, 2'd0, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b1, 8'hFE, 8'hAA, 8'h55, 2'd2, 8'h02, 1'b0, 1'b1, 8'd2);
    // abort in EXEC, then abort beating a real ld rise in GET_B
    add(1'b1, 1'b1, 1'b1, 8'h77, 8'hAA, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'h77, 8'hAA, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b1, 8'h10, 8'h10, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'h10, 8'h10, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b1, 1'b1, 8'h99, 8'h10, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'h99, 8'h10, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b1, 8'h20, 8'h20, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    // ena=0 in GET_B while ld toggles: nothing captured, rise not remembered
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, ((i % 2) == 0), 8'hEE, 8'h20, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'h33, 8'h20, 8'h55, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b1, 8'h33, 8'h20, 8'h33, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'h33, 8'h20, 8'h33, 2'd2, 8'h02, 1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b1, 8'h01, 8'h20, 8'h33, 2'd1, 8'h02, 1'b0, 1'b1, 8'd2);
    add(1'b1, 1'b0, 1'b0, 8'h01, 8'h20, 8'h33, 2'd1, 8'hED, 1'b1, 1'b0, 8'd3);

    tick();
    tick();
    check("rst0_state", pack0(), 36'h0);
    check("rst3_state", {b3.result, b3.res_valid, b3.busy, b3.op_count, b3.alu_a}, 33'h0);
    rst = 1'b0;

    // ALU_LAT=3 instance: busy for exactly 4 samples, result at edge k+4
    pulse(8'hF0);
    pulse(8'h0F);
    din = 8'h03;
    ld  = 1'b1;
    tick();
    ld  = 1'b0;
    check("lat3_busy_k", {b3.busy, b3.res_valid}, 2'b10);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("lat3_busy_k%0d", i), {b3.busy, b3.res_valid}, 2'b10);
    end
    tick();
    check("lat3_done", {b3.busy, b3.res_valid, b3.result, b3.op_count}, {1'b0, 1'b1, 8'hFF, 8'd1});

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < nvec; i++) begin
      ena   = vecs[i].ena;
      abort = vecs[i].abort;
      ld    = vecs[i].ld;
      din   = vecs[i].din;
      tick();
      check($sformatf("vec%0d", i), pack0(),
            {vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].v, vecs[i].busy, vecs[i].cnt});
    end
    ena = 1'b1; abort = 1'b0; ld = 1'b0;

    // op_count wrap: 253 more operations on top of the 3 completed above
    for (int i = 0; i < 253; i++) begin
      pulse(8'(i));
      pulse(8'h01);
      pulse(8'h00);
      if (i == 251) check("cnt_255", b0.op_count, 8'd255);
    end
    check("cnt_wrap", {b0.op_count, b0.res_valid, b0.result}, {8'd0, 1'b1, 8'hFD});

    // ld already high on the first enabled cycle after reset is a rise
    rst = 1'b1;
    ld  = 1'b1;
    tick();
    check("rst_again", pack0(), 36'h0);
    rst = 1'b0;
    din = 8'hC3;
    tick();
    check("ld_high_after_rst", {b0.alu_a, b0.res_valid, b0.busy}, {8'hC3, 1'b0, 1'b0});

    // rst wins over ena=0 and abort
    rst   = 1'b1;
    ena   = 1'b0;
    abort = 1'b1;
    tick();
    check("rst_prio", pack0(), 36'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
